// File: rtl/rv32_pkg.sv
// RV32I encoding definitions shared by the instruction encoder.
// Contents:
//   imm_fmt_e   - ImmSel format codes (R/I/S/B/U/J; 110/111 are invalid)
//   Opc*        - base opcode constants
//   *Lsb        - RV32I field bit positions
//   enc_req_t   - request fields as captured by pipeline stage 1
//   pack_inst() - scatters the fields and the immediate into a 32-bit word
package rv32_pkg;

    typedef enum logic [2:0] {
        FmtR = 3'b000,
        FmtI = 3'b001,
        FmtS = 3'b010,
        FmtB = 3'b011,
        FmtU = 3'b100,
        FmtJ = 3'b101
    } imm_fmt_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned RdLsb     = 7;
    localparam int unsigned Funct3Lsb = 12;
    localparam int unsigned Rs1Lsb    = 15;
    localparam int unsigned Rs2Lsb    = 20;
    localparam int unsigned Funct7Lsb = 25;

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    // Out-of-range immediates are truncated to the listed bits; the legality
    // checker flags them separately. Invalid formats fall back to R packing.
    function automatic logic [31:0] pack_inst(input enc_req_t req);
        logic [31:0] word;
        case (req.sel)
            FmtI: word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            FmtS: word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                          req.opcode};
            FmtB: word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                          req.imm[4:1], req.imm[11], req.opcode};
            FmtU: word = {req.imm[31:12], req.rd, req.opcode};
            FmtJ: word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd,
                          req.opcode};
            default: word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/imm_legal_check.sv
// Immediate legality check for the instruction encoder (combinational).
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   - range/alignment checks per format plus invalid ImmSel
//   undefined - only invalid ImmSel (110/111) is an error
// Ports:
//   ImmSel - format select (rv32_pkg::imm_fmt_e encoding)
//   Imm    - full 32-bit immediate
//   err    - request is illegal
module imm_legal_check
    import rv32_pkg::*;
(
    input  logic [2:0]  ImmSel,
    input  logic [31:0] Imm,
    output logic        err
);

    logic sel_invalid;
    assign sel_invalid = (ImmSel > FmtJ);

`ifdef IMM_RANGE_CHECK_EN
    // A field fits when every bit above its sign bit copies the sign bit.
    logic sext_11, sext_12, sext_20;
    logic range_err;

    assign sext_11 = (&Imm[31:11]) || !(|Imm[31:11]);
    assign sext_12 = (&Imm[31:12]) || !(|Imm[31:12]);
    assign sext_20 = (&Imm[31:20]) || !(|Imm[31:20]);

    always_comb begin
        range_err = 1'b0;
        case (ImmSel)
            FmtI, FmtS: range_err = !sext_11;
            FmtB:       range_err = !sext_12 || Imm[0];
            FmtJ:       range_err = !sext_20 || Imm[0];
            FmtU:       range_err = |Imm[11:0];
            default:    range_err = 1'b0;
        endcase
    end

    assign err = sel_invalid || range_err;
`else
    logic unused_imm;
    assign unused_imm = ^Imm;
    assign err        = sel_invalid;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Two-stage pipelined RV32I instruction packer.
// Stage 1 captures the request; the legality check runs on the captured
// fields. Stage 2 holds the packed word and its error flag.
// Optional feature macro: IMM_RANGE_CHECK_EN (see imm_legal_check).
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   InValid/InReady        - request handshake
//   ImmSel..Imm            - request fields
//   OutValid/OutReady      - result handshake
//   Inst, ImmErr           - packed word and its error flag
//   ErrCount               - saturating count of errored requests
module instruction_encoder
    import rv32_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [2:0]           ImmSel,
    input  logic [6:0]           Opcode,
    input  logic [2:0]           Funct3,
    input  logic [6:0]           Funct7,
    input  logic [4:0]           Rd,
    input  logic [4:0]           Rs1,
    input  logic [4:0]           Rs2,
    input  logic [31:0]          Imm,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [31:0]          Inst,
    output logic                 ImmErr,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    logic                 s1_valid_q, s1_valid_d;
    enc_req_t             s1_req_q, s1_req_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          s2_inst_q, s2_inst_d;
    logic                 s2_err_q, s2_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic s1_err;
    logic s1_adv, s2_adv;

    imm_legal_check u_imm_legal_check (
        .ImmSel (s1_req_q.sel),
        .Imm    (s1_req_q.imm),
        .err    (s1_err)
    );

    assign s2_adv = !s2_valid_q || OutReady;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            // Payload only loads with a real entry so Inst/ImmErr hold across bubbles.
            if (s1_valid_q) begin
                s2_inst_d = pack_inst(s1_req_q);
                s2_err_d  = s1_err;
                if (s1_err && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end

        if (s1_adv) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_req_d.sel    = ImmSel;
                s1_req_d.opcode = Opcode;
                s1_req_d.funct3 = Funct3;
                s1_req_d.funct7 = Funct7;
                s1_req_d.rd     = Rd;
                s1_req_d.rs1    = Rs1;
                s1_req_d.rs2    = Rs2;
                s1_req_d.imm    = Imm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign InReady  = s1_adv;
    assign OutValid = s2_valid_q;
    assign Inst     = s2_inst_q;
    assign ImmErr   = s2_err_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder. Outputs are checked in order against
// a queue of hand-computed words; a narrow ErrCount exposes saturation.
`timescale 1ns/1ps
module tb_instruction_encoder;
    import rv32_pkg::*;

    localparam int unsigned CntW = 3;
    localparam int CntMax = (1 << CntW) - 1;
`ifdef IMM_RANGE_CHECK_EN
    localparam logic RangeChk = 1'b1;
`else
    localparam logic RangeChk = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            InValid;
    logic            InReady;
    logic [2:0]      ImmSel;
    logic [6:0]      Opcode;
    logic [2:0]      Funct3;
    logic [6:0]      Funct7;
    logic [4:0]      Rd;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic [31:0]     Imm;
    logic            OutValid;
    logic            OutReady;
    logic [31:0]     Inst;
    logic            ImmErr;
    logic [CntW-1:0] ErrCount;

    always #5 clk = ~clk;

    instruction_encoder #(
        .ERR_CNT_W (CntW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .ImmSel   (ImmSel),
        .Opcode   (Opcode),
        .Funct3   (Funct3),
        .Funct7   (Funct7),
        .Rd       (Rd),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Imm      (Imm),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Inst     (Inst),
        .ImmErr   (ImmErr),
        .ErrCount (ErrCount)
    );

    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Output scoreboard: a transfer happens on the coming edge when both are high.
    always @(negedge clk) begin
        if (!rst && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("inst", Inst, e[31:0]);
                check("imm_err", 32'(ImmErr), 32'(e[32]));
            end
        end
    end

    // Present one request and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_inst, input logic exp_err);
        bit done = 1'b0;
        ImmSel  = sel;
        Opcode  = op;
        Funct3  = f3;
        Funct7  = f7;
        Rd      = rd;
        Rs1     = rs1;
        Rs2     = rs2;
        Imm     = imm;
        InValid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (InReady) begin
                done = 1'b1;
                exp_q.push_back({exp_err, exp_inst});
                if (exp_err && err_exp < CntMax) err_exp++;
            end
            @(posedge clk);
            #1;
        end
        InValid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        ImmSel   = '0;
        Opcode   = '0;
        Funct3   = '0;
        Funct7   = '0;
        Rd       = '0;
        Rs1      = '0;
        Rs2      = '0;
        Imm      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_inst", Inst, 32'd0);
        check("rst_imm_err", 32'(ImmErr), 32'd0);
        check("rst_err_count", 32'(ErrCount), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(InReady), 32'd1);
        @(posedge clk);
        #1;

        // addi x1,x0,5 with a latency check
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(OutValid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(OutValid), 32'd1);
        check("lat_cycle2_inst", Inst, 32'h0050_0093);
        drain();

        // Main formats, back to back
        send(FmtS, OpcStore, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
        send(FmtB, OpcBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3,
             1'b0);
        send(FmtJ, OpcJal, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        // R ignores Imm
        send(FmtR, OpcOp, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'h0031_00B3, 1'b0);
        send(FmtU, OpcLui, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        drain();
        check("hold_out_valid", 32'(OutValid), 32'd0);
        check("hold_inst", Inst, 32'h1234_52B7);
        check("no_err_count", 32'(ErrCount), 32'd0);

        // Error cases
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h8000_0093,
             RangeChk);
        drain();
        check("err_count_i", 32'(ErrCount), 32'(err_exp));
        send(FmtB, OpcBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0000_0163, RangeChk);
        drain();
        check("err_count_b", 32'(ErrCount), 32'(err_exp));
        send(3'b111, OpcOp, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 32'h4031_00B3, 1'b1);
        drain();
        check("err_count_sel", 32'(ErrCount), 32'(err_exp));

        // Backpressure: two accepts fill the pipe, third cycle stalled
        OutReady = 1'b0;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
        @(negedge clk);
        check("bp_in_ready", 32'(InReady), 32'd0);
        check("bp_out_valid", 32'(OutValid), 32'd1);
        check("bp_inst_stable", Inst, 32'h0010_0093);
        @(posedge clk);
        #1;
        OutReady = 1'b1;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
        drain();

        // Saturation of the narrow counter
        for (int i = 0; i < 9; i++) begin
            send(3'b110, OpcOp, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        end
        drain();
        check("err_count_sat", 32'(ErrCount), 32'(CntMax));

        // Reset with two entries in flight
        OutReady = 1'b0;
        send(3'b111, OpcOp, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        send(3'b111, OpcOp, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(OutValid), 32'd0);
        check("midrst_err_count", 32'(ErrCount), 32'd0);
        check("midrst_inst", Inst, 32'd0);
        exp_q.delete();
        err_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        OutReady = 1'b1;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        drain();
        check("post_rst_inst", Inst, 32'h0050_0093);
        check("post_rst_err_count", 32'(ErrCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
